ce_gen: RTL and testbench



---
 rtl/zx_clk_pkg.sv | 20 ++
 rtl/ce_chan.sv | 59 +++++
 rtl/ce_gen.sv | 124 ++++++++++++
 tb/tb_ce_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zx_clk_pkg.sv
// -----------------------------------------------------------------------------
// zx_clk_pkg
// Shared definitions for the clock-enable generator: FSM state encoding,
// default accumulator width and the common step constants used to derive
// the 3.5 MHz and 7 MHz enables from a 56 MHz reference clock.
// -----------------------------------------------------------------------------
package zx_clk_pkg;

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } ce_state_t;

    localparam int ACC_W_DEF = 16;

    // f_ce = f_ref * step / 2^16, with f_ref = 56 MHz
    localparam logic [15:0] STEP_3M5 = 16'd4096;
    localparam logic [15:0] STEP_7M  = 16'd8192;

endpackage : zx_clk_pkg

// File: rtl/ce_chan.sv
// -----------------------------------------------------------------------------
// ce_chan
// One clock-enable channel: a step register and a phase accumulator. While
// run is high the accumulator adds step every cycle and the carry out of the
// add becomes a single-cycle enable. clr (or run low) zeroes the phase.
//
// Ports
//   refclk  in   reference clock, rising edge
//   rst     in   asynchronous active-high reset
//   run     in   accumulate enable (RUN state with lock still present)
//   clr     in   phase realign request, wins over the carry
//   ld      in   load ld_val into the step register
//   ld_val  in   new step value
//   ce      out  registered one-cycle enable
// -----------------------------------------------------------------------------
module ce_chan #(
    parameter int               ACC_W    = 16,
    parameter logic [ACC_W-1:0] STEP_RST = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic             ld,
    input  logic [ACC_W-1:0] ld_val,
    output logic             ce
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] step_reg;
    logic             ce_reg;
    logic [ACC_W:0]   sum_next;

    // Extra top bit holds the carry, which is the enable.
    assign sum_next = {1'b0, acc_reg} + {1'b0, step_reg};

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc_reg  <= '0;
            step_reg <= STEP_RST;
            ce_reg   <= 1'b0;
        end else begin
            // A step load only affects the next add; the phase is untouched.
            if (ld) begin
                step_reg <= ld_val;
            end
            if (!run || clr) begin
                acc_reg <= '0;
                ce_reg  <= 1'b0;
            end else begin
                acc_reg <= sum_next[ACC_W-1:0];
                ce_reg  <= sum_next[ACC_W];
            end
        end
    end

    assign ce = ce_reg;

endmodule : ce_chan

// File: rtl/ce_gen.sv
// -----------------------------------------------------------------------------
// ce_gen
// Multi-channel fractional clock-enable generator. pll_locked is synchronised
// and must stay high for LOCK_CYCLES consecutive cycles before the channels
// start; losing lock stops and clears all channels on the next edge.
//
// Ports
//   refclk      in   reference (PLL output) clock
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock indication, asynchronous to refclk
//   sync        in   one-cycle request to zero all channel phases (RUN only)
//   wr_en       in   step write strobe
//   wr_ch       in   channel index for the write (>= NCH ignored)
//   wr_step     in   new step value
//   ce          out  per-channel one-cycle enables
//   ready       out  high while in RUN
// -----------------------------------------------------------------------------
module ce_gen
    import zx_clk_pkg::*;
#(
    parameter int                     NCH         = 2,
    parameter int                     ACC_W       = ACC_W_DEF,
    parameter int                     LOCK_CYCLES = 1024,
    parameter logic [NCH*ACC_W-1:0]   STEP_INIT   = {16'd16384, 16'd4096}
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [2:0]       wr_ch,
    input  logic [ACC_W-1:0] wr_step,
    output logic [NCH-1:0]   ce,
    output logic             ready
);

    localparam int               CNT_W    = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    // Two-flop synchroniser for the asynchronous lock input.
    logic lk_meta_reg;
    logic lk_s_reg;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_meta_reg <= 1'b0;
            lk_s_reg    <= 1'b0;
        end else begin
            lk_meta_reg <= pll_locked;
            lk_s_reg    <= lk_meta_reg;
        end
    end

    ce_state_t        state_reg, state_next;
    logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
    logic             run;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_reg    <= WAIT_LOCK;
            lock_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        lock_cnt_next = lock_cnt_reg;
        run           = 1'b0;
        case (state_reg)
            WAIT_LOCK: begin
                if (!lk_s_reg) begin
                    lock_cnt_next = '0;
                end else if (lock_cnt_reg == CNT_LAST) begin
                    lock_cnt_next = '0;
                    state_next    = RUN;
                end else begin
                    lock_cnt_next = lock_cnt_reg + 1'b1;
                end
            end
            RUN: begin
                // Lock loss drops run in the same cycle, so channels clear
                // at the very edge that leaves RUN.
                if (!lk_s_reg) begin
                    lock_cnt_next = '0;
                    state_next    = WAIT_LOCK;
                end else begin
                    run = 1'b1;
                end
            end
            default: begin
                state_next    = WAIT_LOCK;
                lock_cnt_next = '0;
            end
        endcase
    end

    assign ready = (state_reg == RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic ld;
            // Only instantiated channels can match, so wr_ch >= NCH is dropped.
            assign ld = wr_en && (wr_ch == 3'(gi));

            ce_chan #(
                .ACC_W    (ACC_W),
                .STEP_RST (STEP_INIT[gi*ACC_W +: ACC_W])
            ) u_chan (
                .refclk (refclk),
                .rst    (rst),
                .run    (run),
                .clr    (sync),
                .ld     (ld),
                .ld_val (wr_step),
                .ce     (ce[gi])
            );
        end
    endgenerate

endmodule : ce_gen

// File: tb/tb_ce_gen.sv
// -----------------------------------------------------------------------------
// tb_ce_gen
// Self-checking bench for ce_gen (NCH=2, ACC_W=16, LOCK_CYCLES=8). A cycle
// model pushes the expected {ready, ce} into a scoreboard queue when each
// edge's inputs are driven; the entry is popped and compared after the edge.
// Directed counts (latencies, pulse counts) are checked against constants.
// -----------------------------------------------------------------------------
module tb_ce_gen;

    localparam int NCH   = 2;
    localparam int ACC_W = 16;
    localparam int LOCK  = 8;

    logic              refclk = 1'b0;
    logic              rst;
    logic              pll_locked;
    logic              sync;
    logic              wr_en;
    logic [2:0]        wr_ch;
    logic [ACC_W-1:0]  wr_step;
    logic [NCH-1:0]    ce;
    logic              ready;

    always #5 refclk = ~refclk;

    ce_gen #(
        .NCH         (NCH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK),
        .STEP_INIT   ({16'd16384, 16'd4096})
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .sync       (sync),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_step    (wr_step),
        .ce         (ce),
        .ready      (ready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic           ready;
        logic [NCH-1:0] ce;
    } exp_t;

    exp_t        sb_q[$];
    bit          m_s1, m_lks, m_run;
    int          m_cnt;
    int unsigned m_acc[NCH];
    int unsigned m_step[NCH];
    bit [NCH-1:0] m_ce;

    function automatic void model_reset();
        m_s1 = 0; m_lks = 0; m_run = 0; m_cnt = 0; m_ce = '0;
        for (int i = 0; i < NCH; i++) m_acc[i] = 0;
        m_step[0] = 4096;
        m_step[1] = 16384;
    endfunction

    // Advance the model by one edge using the currently driven inputs.
    function automatic void model_edge();
        bit lk_prev;
        int unsigned sum;
        lk_prev = m_lks;
        m_lks   = m_s1;
        m_s1    = pll_locked;
        if (m_run && lk_prev && !sync) begin
            for (int i = 0; i < NCH; i++) begin
                sum       = m_acc[i] + m_step[i];
                m_ce[i]   = (sum >= 32'd65536);
                m_acc[i]  = sum % 32'd65536;
            end
        end else begin
            m_ce = '0;
            for (int i = 0; i < NCH; i++) m_acc[i] = 0;
            if (m_run) begin
                if (!lk_prev) begin
                    m_run = 0;
                    m_cnt = 0;
                end
            end else if (!lk_prev) begin
                m_cnt = 0;
            end else if (m_cnt == LOCK - 1) begin
                m_run = 1;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        if (wr_en && wr_ch < NCH) m_step[wr_ch] = int'(wr_step);
    endfunction

    // One clock: predict, push, clock, pop and compare.
    task automatic tick();
        exp_t e;
        model_edge();
        e.ready = m_run;
        e.ce    = m_ce;
        sb_q.push_back(e);
        @(posedge refclk);
        #1;
        e = sb_q.pop_front();
        check_val("ce", int'(ce), int'(e.ce));
        check_val("ready", int'(ready), int'(e.ready));
    endtask

    task automatic wait_ready(input string tag, input int exp);
        int n = 0;
        while (!ready && n < 60) begin
            tick();
            n++;
        end
        check_val(tag, n, exp);
    endtask

    task automatic edges_to_ce(input string tag, input int ch, input int exp);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!ce[ch] && n < 200);
        check_val(tag, n, exp);
    endtask

    task automatic drive_idle();
        sync = 0; wr_en = 0; wr_ch = '0; wr_step = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first0, first1, cnt0, cnt1, consec;
        bit prev1;

        rst = 1; pll_locked = 1; drive_idle();
        model_reset();
        @(posedge refclk); #1;
        check_val("rst_ce", int'(ce), 0);
        check_val("rst_ready", int'(ready), 0);
        rst = 0;

        // Lock from reset release: 2 sync + LOCK edges.
        wait_ready("lock_latency", LOCK + 2);

        // Default steps: ch0 period 16, ch1 period 4.
        first0 = 0; first1 = 0; cnt0 = 0; cnt1 = 0;
        for (int e = 1; e <= 1000; e++) begin
            tick();
            if (ce[0]) begin cnt0++; if (first0 == 0) first0 = e; end
            if (ce[1]) begin cnt1++; if (first1 == 0) first1 = e; end
        end
        check_val("first_ce0", first0, 16);
        check_val("first_ce1", first1, 4);
        check_val("count_ce0", cnt0, 62);
        check_val("count_ce1", cnt1, 250);

        // ch0 step 0, ch1 ~1/3 from zero phase.
        wr_en = 1; wr_ch = 0; wr_step = 16'h0000; tick();
        wr_ch = 1; wr_step = 16'h5556; sync = 1; tick();
        drive_idle();
        cnt0 = 0; cnt1 = 0; consec = 0; prev1 = 0;
        for (int e = 0; e < 3000; e++) begin
            tick();
            if (ce[0]) cnt0++;
            if (ce[1]) begin cnt1++; if (prev1) consec++; end
            prev1 = ce[1];
        end
        check_val("step0_pulses", cnt0, 0);
        check_val("third_pulses", cnt1, 1000);
        check_val("third_consec", consec, 0);

        // Half-rate step.
        wr_en = 1; wr_ch = 0; wr_step = 16'h8000; sync = 1; tick();
        drive_idle();
        cnt0 = 0;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (ce[0]) cnt0++;
        end
        check_val("half_pulses", cnt0, 50);

        // Sync mid-period at acc=0x7000; wr_ch=5 write in between is ignored.
        wr_en = 1; wr_ch = 0; wr_step = 16'd4096; sync = 1; tick();
        drive_idle();
        for (int e = 0; e < 7; e++) begin
            if (e == 3) begin wr_en = 1; wr_ch = 3'd5; wr_step = 16'h0001; end
            tick();
            drive_idle();
        end
        sync = 1; tick(); drive_idle();
        edges_to_ce("sync_realign", 0, 16);

        // Sync together with a step write: new step from zero phase.
        for (int e = 0; e < 5; e++) tick();
        sync = 1; wr_en = 1; wr_ch = 0; wr_step = 16'd8192; tick();
        drive_idle();
        edges_to_ce("sync_wr", 0, 8);

        // Lock loss in RUN.
        for (int e = 0; e < 3; e++) tick();
        pll_locked = 0;
        begin
            int n = 0;
            while (ready && n < 20) begin tick(); n++; end
            check_val("lock_loss_edges", n, 3);
            check_val("lock_loss_ce", int'(ce), 0);
        end
        for (int e = 0; e < 4; e++) tick();

        // Relock with a one-cycle glitch reaching lk_s at lock_cnt=5.
        pll_locked = 1;
        begin
            int n = 0;
            while (m_cnt != 3 && n < 20) begin tick(); n++; end
        end
        pll_locked = 0; tick();
        pll_locked = 1;
        wait_ready("glitch_relock", LOCK + 2);
        edges_to_ce("relock_first_ce0", 0, 8);

        // Asynchronous reset mid-RUN.
        for (int e = 0; e < 5; e++) tick();
        #2 rst = 1;
        #1;
        check_val("async_rst_ce", int'(ce), 0);
        check_val("async_rst_ready", int'(ready), 0);
        model_reset();
        sb_q.delete();
        @(posedge refclk); #1;
        rst = 0;
        wait_ready("lock_after_rst", LOCK + 2);
        edges_to_ce("rst_step_init", 0, 16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_ce_gen
